mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 19 +
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: word, cache line, arbiter state.
// Imported by the memory arbiter with import lc3b_types::*.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I_BUSY,
    ARB_D_BUSY
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/mem_arbiter.sv
// I/D cache to physical memory arbiter, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin; default is fixed D priority.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_read,
  input  lc3b_word i_address,
  output lc3b_line i_rdata,
  output logic     i_resp,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output lc3b_line d_rdata,
  output logic     d_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  arb_state_t state, state_n;
  logic       d_req;
  logic       pick_d;

  assign d_req   = d_read | d_write;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

`ifdef MEM_ARBITER_RR_EN
  arb_port_t last_grant;

  // On contention the port not granted last time wins.
  assign pick_d = d_req & (~i_read | (last_grant == PORT_I));

  // Remember which port took the most recent grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= PORT_I;
    else if (state == ARB_IDLE && state_n != ARB_IDLE)
      last_grant <= (state_n == ARB_D_BUSY) ? PORT_D : PORT_I;
  end
`else
  assign pick_d = d_req;
`endif

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end

  // Next state plus command and response muxing.
  always_comb begin
    state_n      = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_d)      state_n = ARB_D_BUSY;
        else if (i_read) state_n = ARB_I_BUSY;
      end
      ARB_I_BUSY: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        if (pmem_resp) state_n = ARB_IDLE;
      end
      ARB_D_BUSY: begin
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Scenario tasks plus a transaction-level reference model.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     i_read;
  lc3b_word i_address;
  lc3b_line i_rdata;
  logic     i_resp;
  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  lc3b_line d_rdata;
  logic     d_resp;
  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;

  int passed = 0;
  int total  = 0;

  // Model: owner 0 = nobody, 1 = I port, 2 = D port.
  int owner = 0;
  int last  = 1;

  mem_arbiter dut (
    .clk(clk),
    .reset(reset),
    .i_read(i_read),
    .i_address(i_address),
    .i_rdata(i_rdata),
    .i_resp(i_resp),
    .d_read(d_read),
    .d_write(d_write),
    .d_address(d_address),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_resp(d_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [147:0] obs();
    return {pmem_read, pmem_write, pmem_address,
            pmem_wdata, i_resp, d_resp};
  endfunction

  function automatic logic [147:0] model_out();
    logic [147:0] e;
    e = '0;
    if (owner == 1)
      e = {1'b1, 1'b0, i_address, 128'h0,
           pmem_resp, 1'b0};
    else if (owner == 2)
      e = {d_read & ~d_write, d_write, d_address,
           d_wdata, 1'b0, pmem_resp};
    return e;
  endfunction

  function automatic logic [147:0] model_mask();
    logic [147:0] m;
    m = '1;
    if (owner == 1) m[129:2] = '0;
    return m;
  endfunction

  // Advance one clock and apply the arbitration rules to the model.
  task automatic step();
    int dreq;
    @(posedge clk);
    dreq = int'(d_read | d_write);
    if (reset) begin
      owner = 0;
      last  = 1;
    end else if (owner == 0) begin
      if (dreq == 1 && i_read) begin
`ifdef MEM_ARBITER_RR_EN
        owner = (last == 1) ? 2 : 1;
`else
        owner = 2;
`endif
      end else if (dreq == 1) owner = 2;
      else if (i_read)        owner = 1;
      if (owner != 0) last = owner;
    end else if (pmem_resp) begin
      owner = 0;
    end
  endtask

  task automatic idle_inputs();
    i_read     = 1'b0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    pmem_resp  = 1'b0;
    i_address  = '0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset      = 1'b1;
    i_read     = 1'b1;
    d_read     = 1'b1;
    d_write    = 1'b1;
    d_address  = 16'hBEEF;
    d_wdata    = {4{32'hDEADBEEF}};
    pmem_resp  = 1'b1;
    pmem_rdata = {4{32'h5A5A1234}};
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL reset_outputs: got %h want 0", obs());
    else passed++;
    total++;
    if (i_rdata !== pmem_rdata || d_rdata !== pmem_rdata)
      $display("FAIL reset_rdata: got %h/%h want %h",
               i_rdata, d_rdata, pmem_rdata);
    else passed++;
    step();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL reset_idle: got %h want 0", obs());
    else passed++;
  endtask

  task automatic test_ifill();
    lc3b_line a5;
    a5 = {16{8'hA5}};
    @(negedge clk);
    i_read    = 1'b1;
    i_address = 16'h1230;
    step();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      pmem_resp  = (k == 5);
      pmem_rdata = (k == 5) ? a5 : '0;
      if (k == 5) i_read = 1'b0;
      #1;
      total++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 ||
          pmem_address !== 16'h1230)
        $display("FAIL ifill_cmd%0d: got %b%b %h want 10 1230",
                 k, pmem_read, pmem_write, pmem_address);
      else passed++;
      total++;
      if (i_resp !== (k == 5) || d_resp !== 1'b0)
        $display("FAIL ifill_resp%0d: got %b%b want %b0",
                 k, i_resp, d_resp, k == 5);
      else passed++;
    end
    total++;
    if (i_rdata !== a5)
      $display("FAIL ifill_rdata: got %h want %h", i_rdata, a5);
    else passed++;
    step();
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL ifill_done: got %h want 0", obs());
    else passed++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    reset     = 1'b0;
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 16'h1111;
    d_address = 16'h2222;
    step();
    @(negedge clk);
    #1;
    total++;
    if (pmem_address !== 16'h2222 || pmem_read !== 1'b1)
      $display("FAIL prio_first: got %h %b want 2222 1",
               pmem_address, pmem_read);
    else passed++;
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL prio_dresp: got %b%b want 01",
               i_resp, d_resp);
    else passed++;
    step();
    @(negedge clk);
    d_read    = 1'b0;
    pmem_resp = 1'b0;
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL prio_gap: got %h want 0", obs());
    else passed++;
    step();
    @(negedge clk);
    #1;
    total++;
    if (pmem_address !== 16'h1111 || pmem_read !== 1'b1)
      $display("FAIL prio_second: got %h %b want 1111 1",
               pmem_address, pmem_read);
    else passed++;
    pmem_resp = 1'b1;
    i_read    = 1'b0;
    step();
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  task automatic test_contention();
    lc3b_word want [6];
`ifdef MEM_ARBITER_RR_EN
    want = '{16'h0D0D, 16'h0101, 16'h0D0D,
             16'h0101, 16'h0D0D, 16'h0101};
`else
    want = '{16'h0D0D, 16'h0D0D, 16'h0D0D,
             16'h0D0D, 16'h0D0D, 16'h0D0D};
`endif
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    reset     = 1'b0;
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 16'h0101;
    d_address = 16'h0D0D;
    for (int g = 0; g < 6; g++) begin
      step();
      @(negedge clk);
      #1;
      total++;
      if (pmem_address !== want[g])
        $display("FAIL grant%0d: got %h want %h",
                 g, pmem_address, want[g]);
      else passed++;
      pmem_resp = 1'b1;
      step();
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_writeback();
    lc3b_line wd;
    wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    @(negedge clk);
    d_write   = 1'b1;
    d_address = 16'h4000;
    d_wdata   = wd;
    step();
    @(negedge clk);
    #1;
    total++;
    if (obs() !== {2'b01, 16'h4000, wd, 2'b00})
      $display("FAIL wb_cmd: got %h want 01 4000 %h", obs(), wd);
    else passed++;
    pmem_resp = 1'b1;
    #1;
    total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL wb_resp: got %b%b want 01", i_resp, d_resp);
    else passed++;
    step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_read    = 1'b1;
    i_address = 16'h7777;
    step();
    @(negedge clk);
    #1;
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h7777)
      $display("FAIL rmid_busy: got %b %h want 1 7777",
               pmem_read, pmem_address);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL rmid_async: got %h want 0", obs());
    else passed++;
    step();
    @(negedge clk);
    reset     = 1'b0;
    i_read    = 1'b0;
    pmem_resp = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b0 || obs() !== '0)
      $display("FAIL rmid_noresp: got %b %h want 0",
               i_resp, obs());
    else passed++;
    step();
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  task automatic test_abort_stray();
    @(negedge clk);
    i_read    = 1'b1;
    i_address = 16'h3C3C;
    step();
    @(negedge clk);
    i_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (pmem_read !== 1'b1 || i_resp !== 1'b0)
        $display("FAIL abort_hold%0d: got %b%b want 10",
                 k, pmem_read, i_resp);
      else passed++;
      step();
      @(negedge clk);
    end
    pmem_resp = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b1)
      $display("FAIL abort_resp: got %b want 1", i_resp);
    else passed++;
    step();
    @(negedge clk);
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL stray_resp: got %h want 0", obs());
    else passed++;
    step();
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total++;
    if (obs() !== '0)
      $display("FAIL stray_after: got %h want 0", obs());
    else passed++;
  endtask

  // Caches hold each request until answered; memory responds at random.
  task automatic test_random();
    logic [147:0] m;
    int served;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!i_read && $urandom_range(2) == 0) begin
        i_read    = 1'b1;
        i_address = 16'($urandom);
      end
      if (!(d_read | d_write) && $urandom_range(2) == 0) begin
        d_read    = 1'($urandom);
        d_write   = ~d_read | ($urandom_range(3) == 0);
        d_address = 16'($urandom);
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem_resp  = ($urandom_range(2) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      m = model_mask();
      total++;
      if ((obs() & m) !== (model_out() & m))
        $display("FAIL rand%0d: got %h want %h",
                 c, obs() & m, model_out() & m);
      else passed++;
      total++;
      if (i_rdata !== pmem_rdata || d_rdata !== pmem_rdata)
        $display("FAIL rand_rdata%0d: got %h/%h want %h",
                 c, i_rdata, d_rdata, pmem_rdata);
      else passed++;
      served = pmem_resp ? owner : 0;
      step();
      if (served == 1) i_read = 1'b0;
      if (served == 2) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_ifill();
    test_priority();
    test_contention();
    test_writeback();
    test_reset_mid();
    test_abort_stray();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
